// File: rtl/mem_pkg.sv
// mem_pkg: line geometry, write-buffer entry type and FSM states shared by the write buffer.
package mem_pkg;
  localparam int ADDR_W      = 32;
  localparam int LINE_BYTES  = 32;
  localparam int LINE_W      = LINE_BYTES * 8;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int TAG_W       = ADDR_W - OFFSET_BITS;
  typedef logic [TAG_W-1:0]  line_tag_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef struct packed {
    logic      valid;
    line_tag_t tag;
    line_t     data;
  } wb_entry_t;
  typedef enum logic [1:0] {IDLE, HIT_RSP, RD_REQ, RD_WAIT} wb_state_e;
  function automatic logic [ADDR_W-1:0] line_addr(input line_tag_t t);
    return {t, {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/wb_entry_array.sv
// wb_entry_array: circular buffer of dirty lines with parallel tag match, coalescing enqueue and head pop.
module wb_entry_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr,
  input  line_tag_t                i_tag,
  input  line_t                    i_wdata,
  input  logic                     i_pop,
  output logic                     o_hit,
  output line_t                    o_hit_data,
  output line_tag_t                o_head_tag,
  output line_t                    o_head_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t        r_ent [DEPTH];
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] w_match;
  logic [PW-1:0]    w_idx;
  logic             w_coal, w_push;
  always_comb begin
    w_match = '0;
    w_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_ent[i].valid && (r_ent[i].tag == i_tag);
      if (w_match[i]) w_idx = PW'(i);
    end
  end
  assign o_hit       = |w_match;
  assign o_hit_data  = r_ent[w_idx].data;
  assign o_head_tag  = r_ent[r_head].tag;
  assign o_head_data = r_ent[r_head].data;
  assign o_count     = r_count;
  // a match on the head that leaves this cycle must not be overwritten; it gets a fresh tail slot
  assign w_coal = i_wr && o_hit && !(i_pop && (w_idx == r_head));
  assign w_push = i_wr && !w_coal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) begin
        r_ent[r_head].valid <= 1'b0;
        r_head              <= r_head + PW'(1);
      end
      if (w_coal) r_ent[w_idx].data <= i_wdata;
      if (w_push) begin
        r_ent[r_tail] <= '{valid: 1'b1, tag: i_tag, data: i_wdata};
        r_tail        <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(i_pop);
    end
  end
endmodule

// File: rtl/line_write_buffer.sv
// line_write_buffer: posted line writeback buffer with local read hits and read-miss priority over drain.
module line_write_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cache_req_valid,
  output logic                   cache_req_ready,
  input  logic                   cache_req_rw,
  input  logic [ADDR_W-1:0]      cache_req_addr,
  input  line_t                  cache_req_wline,
  output logic                   cache_resp_valid,
  output line_t                  cache_resp_rline,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_W-1:0]      mem_req_addr,
  output line_t                  mem_req_wline,
  input  logic                   mem_resp_valid,
  input  line_t                  mem_resp_rline,
  output logic                   wb_empty,
  output logic [$clog2(DEPTH):0] wb_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  wb_state_e     r_state;
  logic          r_hit_valid;
  line_t         r_rline;
  line_tag_t     r_rd_tag;
  line_tag_t     w_tag, w_head_tag;
  line_t         w_hit_data, w_head_data;
  logic          w_hit, w_accept, w_drain, w_pop, w_unused;
  logic [CW-1:0] w_count;
  assign w_tag           = cache_req_addr[ADDR_W-1:OFFSET_BITS];
  assign w_unused        = ^cache_req_addr[OFFSET_BITS-1:0];
  assign cache_req_ready = (r_state == IDLE) && (w_count < CW'(DEPTH));
  assign w_accept        = cache_req_valid && cache_req_ready;
  // a pending read miss never aliases a buffered line, so drain may overlap RD_WAIT
  assign w_drain         = (r_state != RD_REQ) && (w_count != '0);
  assign w_pop           = w_drain && mem_req_ready;
  wb_entry_array #(.DEPTH(DEPTH)) u_entries (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr        (w_accept && cache_req_rw),
    .i_tag       (w_tag),
    .i_wdata     (cache_req_wline),
    .i_pop       (w_pop),
    .o_hit       (w_hit),
    .o_hit_data  (w_hit_data),
    .o_head_tag  (w_head_tag),
    .o_head_data (w_head_data),
    .o_count     (w_count)
  );
  assign mem_req_valid    = (r_state == RD_REQ) || w_drain;
  assign mem_req_rw       = r_state != RD_REQ;
  assign mem_req_addr     = line_addr((r_state == RD_REQ) ? r_rd_tag : w_head_tag);
  assign mem_req_wline    = w_head_data;
  assign cache_resp_valid = (r_state == RD_WAIT) ? mem_resp_valid : r_hit_valid;
  assign cache_resp_rline = (r_state == RD_WAIT) ? mem_resp_rline : r_rline;
  assign wb_empty         = w_count == '0;
  assign wb_count         = w_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hit_valid <= 1'b0;
      r_rline     <= '0;
      r_rd_tag    <= '0;
    end else begin
      r_hit_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept && !cache_req_rw) begin
          if (w_hit) begin
            r_state     <= HIT_RSP;
            r_hit_valid <= 1'b1;
            r_rline     <= w_hit_data;
          end else begin
            r_state  <= RD_REQ;
            r_rd_tag <= w_tag;
          end
        end
        HIT_RSP: r_state <= IDLE;
        RD_REQ:  if (mem_req_ready) r_state <= RD_WAIT;
        RD_WAIT: if (mem_resp_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_write_buffer.sv
// tb_line_write_buffer: directed vectors plus hand sequences for hits, coalescing, full stall, read miss and reset.
module tb_line_write_buffer;
  import mem_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cache_req_valid = 1'b0, cache_req_rw = 1'b0;
  logic [31:0] cache_req_addr = '0;
  line_t       cache_req_wline = '0;
  logic        cache_req_ready, cache_resp_valid;
  line_t       cache_resp_rline;
  logic        mem_req_valid, mem_req_rw;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  line_t       mem_req_wline;
  logic        mem_resp_valid;
  line_t       mem_resp_rline;
  logic        wb_empty;
  logic [2:0]  wb_count;
  always #5 clk = ~clk;
  line_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
    .cache_req_rw(cache_req_rw), .cache_req_addr(cache_req_addr), .cache_req_wline(cache_req_wline),
    .cache_resp_valid(cache_resp_valid), .cache_resp_rline(cache_resp_rline),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wline(mem_req_wline),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rline(mem_resp_rline),
    .wb_empty(wb_empty), .wb_count(wb_count)
  );
  function automatic line_t lw(input int k);
    return {8{32'hC0DE_0000 + 32'(k)}};
  endfunction
  function automatic line_t mem_line(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction
  // memory model: logs every accepted request, answers reads 5 cycles after acceptance
  typedef struct { logic rw; logic [31:0] addr; line_t data; } mem_op_t;
  mem_op_t     log_q[$];
  int          rd_cnt;
  logic [31:0] rd_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt         <= 0;
      rd_addr        <= '0;
      mem_resp_valid <= 1'b0;
      mem_resp_rline <= '0;
    end else begin
      mem_resp_valid <= rd_cnt == 1;
      mem_resp_rline <= (rd_cnt == 1) ? mem_line(rd_addr) : '0;
      if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
      if (mem_req_valid && mem_req_ready) begin
        log_q.push_back('{mem_req_rw, mem_req_addr, mem_req_wline});
        if (!mem_req_rw) begin
          rd_cnt  <= 5;
          rd_addr <= mem_req_addr;
        end
      end
    end
  end
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_log(input string nm, input int idx, input logic rw, input logic [31:0] a, input line_t d);
    if (idx < log_q.size()) begin
      chk({nm, "_rw"}, log_q[idx].rw, rw);
      chk({nm, "_addr"}, log_q[idx].addr, a);
      if (rw) chk({nm, "_data"}, log_q[idx].data, d);
    end else chk({nm, "_present"}, log_q.size(), idx + 1);
  endtask
  task automatic req(input logic rw, input logic [31:0] a, input line_t d);
    int t = 0;
    @(negedge clk);
    cache_req_valid = 1'b1; cache_req_rw = rw; cache_req_addr = a; cache_req_wline = d;
    #1;
    while (!cache_req_ready && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("req_accept", cache_req_ready, 1'b1);
    @(posedge clk); #1;
    cache_req_valid = 1'b0;
  endtask
  typedef struct {
    logic v, rw; logic [31:0] a; line_t d; logic mr;
    logic e_rdy, e_rv; line_t e_rd; logic e_mv, e_mw; logic [31:0] e_ma; line_t e_md; logic [2:0] e_cnt;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic v, rw, input logic [31:0] a, input line_t d, input logic mr,
                     input logic e_rdy, e_rv, input line_t e_rd, input logic e_mv, e_mw,
                     input logic [31:0] e_ma, input line_t e_md, input logic [2:0] e_cnt);
    vq.push_back('{v, rw, a, d, mr, e_rdy, e_rv, e_rd, e_mv, e_mw, e_ma, e_md, e_cnt});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int t, base;
    //   v rw addr      data     mr | rdy rv rd      mv mw addr      wdata    cnt
    add(0, 0, 32'h00, '0,     0,   1, 0, '0,     0, 0, 32'h00, '0,     0);
    add(1, 1, 32'h40, lw(1),  0,   1, 0, '0,     0, 0, 32'h00, '0,     0);
    add(1, 0, 32'h40, '0,     0,   1, 0, '0,     1, 1, 32'h40, lw(1),  1);
    add(0, 0, 32'h00, '0,     0,   0, 1, lw(1),  1, 1, 32'h40, lw(1),  1);
    add(0, 0, 32'h00, '0,     0,   1, 0, '0,     1, 1, 32'h40, lw(1),  1);
    add(1, 1, 32'h5F, lw(2),  0,   1, 0, '0,     1, 1, 32'h40, lw(1),  1);
    add(0, 0, 32'h00, '0,     1,   1, 0, '0,     1, 1, 32'h40, lw(2),  1);
    add(0, 0, 32'h00, '0,     0,   1, 0, '0,     0, 0, 32'h00, '0,     0);
    add(1, 1, 32'h00, lw(16), 0,   1, 0, '0,     0, 0, 32'h00, '0,     0);
    add(1, 1, 32'h20, lw(17), 0,   1, 0, '0,     1, 1, 32'h00, lw(16), 1);
    add(1, 1, 32'h40, lw(18), 0,   1, 0, '0,     1, 1, 32'h00, lw(16), 2);
    add(1, 1, 32'h60, lw(19), 0,   1, 0, '0,     1, 1, 32'h00, lw(16), 3);
    add(1, 1, 32'h80, lw(20), 0,   0, 0, '0,     1, 1, 32'h00, lw(16), 4);
    add(1, 1, 32'h80, lw(20), 1,   0, 0, '0,     1, 1, 32'h00, lw(16), 4);
    add(1, 1, 32'h80, lw(20), 0,   1, 0, '0,     1, 1, 32'h20, lw(17), 3);
    add(0, 0, 32'h00, '0,     0,   0, 0, '0,     1, 1, 32'h20, lw(17), 4);
    add(0, 0, 32'h00, '0,     1,   0, 0, '0,     1, 1, 32'h20, lw(17), 4);
    add(0, 0, 32'h00, '0,     1,   1, 0, '0,     1, 1, 32'h40, lw(18), 3);
    add(0, 0, 32'h00, '0,     1,   1, 0, '0,     1, 1, 32'h60, lw(19), 2);
    add(0, 0, 32'h00, '0,     1,   1, 0, '0,     1, 1, 32'h80, lw(20), 1);
    add(0, 0, 32'h00, '0,     0,   1, 0, '0,     0, 0, 32'h00, '0,     0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      cache_req_valid = vq[i].v; cache_req_rw = vq[i].rw; cache_req_addr = vq[i].a;
      cache_req_wline = vq[i].d; mem_req_ready = vq[i].mr;
      #1;
      chk($sformatf("v%0d_ready", i), cache_req_ready, vq[i].e_rdy);
      chk($sformatf("v%0d_resp_valid", i), cache_resp_valid, vq[i].e_rv);
      if (vq[i].e_rv) chk($sformatf("v%0d_resp_data", i), cache_resp_rline, vq[i].e_rd);
      chk($sformatf("v%0d_mem_valid", i), mem_req_valid, vq[i].e_mv);
      if (vq[i].e_mv) begin
        chk($sformatf("v%0d_mem_rw", i), mem_req_rw, vq[i].e_mw);
        chk($sformatf("v%0d_mem_addr", i), mem_req_addr, vq[i].e_ma);
        if (vq[i].e_mw) chk($sformatf("v%0d_mem_wdata", i), mem_req_wline, vq[i].e_md);
      end
      chk($sformatf("v%0d_count", i), wb_count, vq[i].e_cnt);
      chk($sformatf("v%0d_empty", i), wb_empty, vq[i].e_cnt == 3'd0);
    end
    chk("tbl_log_size", log_q.size(), 6);
    chk_log("tbl_log0", 0, 1, 32'h40, lw(2));
    chk_log("tbl_log1", 1, 1, 32'h00, lw(16));
    chk_log("tbl_log2", 2, 1, 32'h20, lw(17));
    chk_log("tbl_log3", 3, 1, 32'h40, lw(18));
    chk_log("tbl_log4", 4, 1, 32'h60, lw(19));
    chk_log("tbl_log5", 5, 1, 32'h80, lw(20));
    // read miss overtakes the two pending drains, which then finish while the read is outstanding
    cache_req_valid = 1'b0; mem_req_ready = 1'b0;
    req(1, 32'h00, lw(5));
    req(1, 32'h20, lw(6));
    base = log_q.size();
    req(0, 32'h100, '0);
    @(negedge clk); #1;
    chk("miss_mem_valid", mem_req_valid, 1'b1);
    chk("miss_mem_rw", mem_req_rw, 1'b0);
    chk("miss_mem_addr", mem_req_addr, 32'h100);
    chk("miss_count", wb_count, 3'd2);
    mem_req_ready = 1'b1;
    t = 0;
    @(negedge clk); #1;
    while (!cache_resp_valid && t < 30) begin
      @(negedge clk); #1; t++;
    end
    chk("miss_resp_seen", cache_resp_valid, 1'b1);
    chk("miss_resp_data", cache_resp_rline, mem_line(32'h100));
    chk("miss_drained", wb_count, 3'd0);
    mem_req_ready = 1'b0;
    chk("miss_log_size", log_q.size(), base + 3);
    chk_log("miss_log0", base, 0, 32'h100, '0);
    chk_log("miss_log1", base + 1, 1, 32'h00, lw(5));
    chk_log("miss_log2", base + 2, 1, 32'h20, lw(6));
    // read hit on the head entry in the very cycle it drains
    req(1, 32'h00, lw(8));
    base = log_q.size();
    @(negedge clk);
    cache_req_valid = 1'b1; cache_req_rw = 1'b0; cache_req_addr = 32'h00; mem_req_ready = 1'b1;
    #1;
    chk("race_ready", cache_req_ready, 1'b1);
    chk("race_drain_valid", mem_req_valid, 1'b1);
    chk("race_drain_addr", mem_req_addr, 32'h00);
    @(posedge clk); #1;
    cache_req_valid = 1'b0; mem_req_ready = 1'b0;
    @(negedge clk); #1;
    chk("race_resp_valid", cache_resp_valid, 1'b1);
    chk("race_resp_data", cache_resp_rline, lw(8));
    chk("race_count", wb_count, 3'd0);
    @(negedge clk); #1;
    chk("race_resp_pulse", cache_resp_valid, 1'b0);
    chk("race_log_size", log_q.size(), base + 1);
    chk_log("race_log0", base, 1, 32'h00, lw(8));
    // reset while a read is outstanding with two lines still buffered
    req(1, 32'h00, lw(9));
    req(1, 32'h20, lw(10));
    req(0, 32'h200, '0);
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk("rst_rd_addr", mem_req_addr, 32'h200);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_pre_count", wb_count, 3'd2);
    chk("rst_pre_ready", cache_req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", cache_resp_valid, 1'b0);
    chk("rst_resp_data", cache_resp_rline, '0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_empty", wb_empty, 1'b1);
    chk("rst_count", wb_count, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", cache_req_ready, 1'b1);
    chk("post_rst_mem_valid", mem_req_valid, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_no_resp", cache_resp_valid, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
